// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule.
// Runs the key expansion forward from K0 to K10 at one round per cycle. It then
// emits K10 down to K0 over a valid/ready handshake, undoing one round per
// accepted key. A single SubWord unit (four S-box lookups) serves both
// directions.
module aes_inv_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         ready_in,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StFwd, StOut} state_e;

    // Forward AES S-box, entry 0 first.
    localparam logic [0:255][7:0] Sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {Sbox[w[31:24]], Sbox[w[23:16]], Sbox[w[15:8]], Sbox[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] rc;
        rc = 8'h00;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sub_in, sub_out, rcon_word;
    logic [3:0]   rcon_idx;
    logic [31:0]  f0, f1, f2, f3;
    logic [31:0]  p0, p1, p2, p3;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Round datapath: shared SubWord, then forward and inverse round candidates.
    always_comb begin
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        // Undoing round r needs SubWord of the previous w3, which is w3 ^ w2.
        if (state_q == StOut) begin
            sub_in   = rot_word(p3);
            rcon_idx = idx_q;
        end else begin
            sub_in   = rot_word(w3);
            rcon_idx = idx_q + 4'd1;
        end
        sub_out   = sub_word(sub_in);
        rcon_word = {rcon_of(rcon_idx), 24'h000000};
        f0 = w0 ^ sub_out ^ rcon_word;
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        f3 = w3 ^ f2;
        p0 = w0 ^ sub_out ^ rcon_word;
    end

    // Next-state logic for the schedule sequencer.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key_in;
                    idx_d   = 4'd0;
                    state_d = StFwd;
                end
            end
            StFwd: begin
                key_d = {f0, f1, f2, f3};
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd9) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (ready_in) begin
                    if (idx_q == 4'd0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        key_d = {p0, p1, p2, p3};
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, key and index registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign round_key = key_q;
    assign round_idx = idx_q;
    assign key_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule: a transaction-level model plus
// literal FIPS-197 vectors.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         ready_in = 1'b1;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    aes_inv_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .ready_in  (ready_in),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    bit ready_mode = 1'b0;
    logic [7:0] sbox_tab [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv, base, s;
        logic [7:0] e;
        for (int x = 0; x < 256; x++) begin
            inv  = 8'h01;
            base = x[7:0];
            e    = 8'd254;
            for (int b = 0; b < 8; b++) begin
                if (e[b]) inv = gmul(inv, base);
                base = gmul(base, base);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_tab[x] = s;
        end
    endtask

    // Round key r obtained by expanding k0 forward r rounds.
    function automatic logic [127:0] fwd_round_key(input logic [127:0] k0, input int r);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = k0[127:96];
        w[1] = k0[95:64];
        w[2] = k0[63:32];
        w[3] = k0[31:0];
        rc = 8'h01;
        for (int i = 1; i <= r; i++) begin
            t = {w[3][23:0], w[3][31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
            w[0] = w[0] ^ t ^ {rc, 24'h000000};
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc = xtime(rc);
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Transaction-level model: 10-cycle latency, then keys 10..0 one per handshake.
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_done = 1'b0;
    int          m_wait = 0;
    int          m_idx = 0;
    logic [127:0] m_k0 = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_done  <= 1'b0;
            m_wait  <= 0;
            m_idx   <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_k0   <= key_in;
                    m_busy <= 1'b1;
                    m_wait <= 10;
                end
            end else if (m_wait > 0) begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) begin
                    m_valid <= 1'b1;
                    m_idx   <= 10;
                end
            end else if (ready_in) begin
                if (m_idx == 0) begin
                    m_valid <= 1'b0;
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                end else begin
                    m_idx <= m_idx - 1;
                end
            end
        end
    end

    // Handshake and cycle counters observed at the clock edge.
    int hs = 0;
    int cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hs <= 0;
        end else if (done) begin
            hs <= 0;
        end else if (key_valid && ready_in) begin
            hs <= hs + 1;
        end
        if (!rst) cyc <= cyc + 1;
    end

    // Compare DUT against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("busy", 128'(busy), 128'(m_busy));
            check("key_valid", 128'(key_valid), 128'(m_valid));
            check("done", 128'(done), 128'(m_done));
            if (m_valid) begin
                check("round_idx", 128'(round_idx), 128'(m_idx));
                check("round_key", round_key, fwd_round_key(m_k0, m_idx));
            end
            if (done) check("handshakes", 128'(hs), 128'd11);
        end
    end

    // ready_in driver: constant 1 or random backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_in = ready_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic start_sched(input logic [127:0] k);
        @(posedge clk);
        #1;
        key_in = k;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_for_idx(input int idx, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(key_valid && round_idx == idx[3:0]) && n < limit);
        if (!(key_valid && round_idx == idx[3:0])) begin
            checks++;
            failures++;
            $display("FAIL wait_idx%0d: timed out after %0d cycles, required key_valid", idx, n);
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < limit);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_done: timed out after %0d cycles, required done=1", n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] kb;
        int c0;
        int n;
        build_sbox();

        // Pin the model against published vectors.
        check("model_fips_k10", fwd_round_key(FipsKey, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_fips_k1", fwd_round_key(FipsKey, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        check("model_zero_k10", fwd_round_key('0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Asynchronous reset state, checked between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("rst_round_key", round_key, '0);
        check("rst_round_idx", 128'(round_idx), '0);
        check("rst_key_valid", 128'(key_valid), '0);
        check("rst_busy", 128'(busy), '0);
        check("rst_done", 128'(done), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        // FIPS-197 key, ready held high: exact latency and literal keys.
        @(posedge clk);
        #1;
        key_in = FipsKey;
        start  = 1'b1;
        @(posedge clk);
        #1;
        c0     = cyc;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("fips_not_valid_at_9", 128'(key_valid), 128'd0);
        @(negedge clk);
        check("fips_valid_at_10", 128'(key_valid), 128'd1);
        check("fips_idx10", 128'(round_idx), 128'd10);
        check("fips_k10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_for_idx(1, 20);
        check("fips_k1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        wait_for_idx(0, 5);
        check("fips_k0", round_key, FipsKey);
        @(negedge clk);
        check("fips_done", 128'(done), 128'd1);
        check("fips_21_cycles", 128'(cyc - c0), 128'd21);

        // Same key under random backpressure.
        ready_mode = 1'b1;
        start_sched(FipsKey);
        wait_done(400);
        ready_mode = 1'b0;

        // All-zero key.
        start_sched('0);
        wait_for_idx(10, 30);
        check("zero_k10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        wait_for_idx(0, 30);
        check("zero_k0", round_key, '0);
        wait_done(5);

        // start while busy, in FWD and in OUT.
        ready_mode = 1'b1;
        start_sched({$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_for_idx(7, 200);
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(300);

        // Reset mid-OUT, then a fresh schedule.
        start_sched({$urandom, $urandom, $urandom, $urandom});
        wait_for_idx(5, 300);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_round_key", round_key, '0);
        check("midrst_round_idx", 128'(round_idx), '0);
        check("midrst_key_valid", 128'(key_valid), '0);
        check("midrst_busy", 128'(busy), '0);
        check("midrst_done", 128'(done), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 1'b0;
        repeat (4) @(posedge clk);
        start_sched({$urandom, $urandom, $urandom, $urandom});
        wait_done(100);

        // Back-to-back: second start issued in the done cycle.
        start_sched({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 100);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL b2b_done_wait: got done=0 after %0d cycles, required done=1", n);
        end
        kb     = {$urandom, $urandom, $urandom, $urandom};
        key_in = kb;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_done_one_cycle", 128'(done), 128'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("b2b_not_valid_at_9", 128'(key_valid), 128'd0);
        @(negedge clk);
        check("b2b_valid_at_10", 128'(key_valid), 128'd1);
        check("b2b_k10", round_key, fwd_round_key(kb, 10));
        wait_done(30);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
